tone_scheduler: RTL and testbench
=================================

TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 Parameter TICKS_PER_MS, default 32'd50_000: in_clk cycles per millisecond time base.
REQ-002 Parameter NOTE_MS, default 16'd500: sequencer note-on duration in ms.
REQ-003 Parameter GAP_MS, default 16'd50: sequencer silence between notes in ms.
REQ-004 in_clk  input  1  sole clock; one clock, all logic on posedge in_clk.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 key_req  input  8  live note requests, bit i = note i held, active-high, already synchronous.
REQ-007 play_start  input  1  single-cycle pulse, start scale playback.
REQ-008 play_stop  input  1  single-cycle pulse, abort playback.
REQ-009 freq_out  output  32  frequency in Hz for the downstream clock divider; never zero.
REQ-010 tone_en  output  1  1 = tone audible, 0 = silence.
REQ-011 busy  output  1  1 whenever state is not IDLE.
REQ-012 note_idx  output  3  index of the note currently selected.

Function
REQ-013 Note table (index 0..7) SHALL be 262, 294, 330, 349, 392, 440, 494, 523 Hz.
REQ-014 FSM states SHALL be IDLE, LIVE, SEQ_NOTE, SEQ_GAP.
REQ-015 All outputs SHALL be registered; response to an input sampled at edge N is visible after edge N+1 (latency 1 cycle).
REQ-016 IDLE: key_req != 0 -> LIVE; else play_start=1 and play_stop=0 -> SEQ_NOTE with note_idx=0; else stay.
REQ-017 Key arbitration SHALL be fixed priority, lowest set bit of key_req wins.
REQ-018 LIVE: each cycle freq_out/note_idx track the winning key, tone_en=1; key_req==0 -> IDLE with tone_en=0.
REQ-019 LIVE SHALL ignore play_start and play_stop.
REQ-020 SEQ_NOTE: tone_en=1, freq_out = table[note_idx], lasting exactly NOTE_MS*TICKS_PER_MS cycles, then -> SEQ_GAP.
REQ-021 SEQ_GAP: tone_en=0, freq_out held, lasting exactly GAP_MS*TICKS_PER_MS cycles; then note_idx<7 -> SEQ_NOTE with note_idx+1, note_idx==7 -> IDLE.
REQ-022 Any key_req != 0 in SEQ_NOTE or SEQ_GAP SHALL abort the sequence and enter LIVE next cycle (keys preempt playback).
REQ-023 play_stop in SEQ_NOTE/SEQ_GAP -> IDLE next cycle, tone_en=0; key_req != 0 on the same cycle -> LIVE instead.
REQ-024 play_start during SEQ_NOTE/SEQ_GAP SHALL be ignored (no restart).
REQ-025 Simultaneous play_start and play_stop in IDLE: stay IDLE.
REQ-026 ms prescaler and ms counter SHALL clear on every entry to SEQ_NOTE or SEQ_GAP so durations are exact, with no leftover partial ms.
REQ-027 In IDLE, freq_out SHALL hold its last value (never 0) with tone_en=0.
REQ-028 Duration counters SHALL be 32-bit, no wrap within the maximum parameter product.

Reset
REQ-029 On reset: state=IDLE, freq_out=32'd262, tone_en=0, busy=0, note_idx=0, prescaler and ms counters 0.
REQ-030 Reset asserted mid-sequence SHALL take priority over all inputs and silence the output on the following edge.

Structure
REQ-031 Package tone_pkg SHALL hold the note frequency table, the state enum type, and the NOTE_COUNT=8 constant.
REQ-032 Sub-module ms_tick_gen SHALL produce a 1-cycle ms_tick every TICKS_PER_MS cycles, with a synchronous clear input.

Verification (TICKS_PER_MS=2, NOTE_MS=3, GAP_MS=1)
REQ-033 Reset, then idle 10 cycles -> freq_out=262, tone_en=0, busy=0 throughout.
REQ-034 play_start pulse at edge N -> tone_en=1, freq 262 for cycles N+1..N+6, tone_en=0 for N+7..N+8, freq 294 from N+9; after note 7 gap, busy=0 at N+65.
REQ-035 key_req=8'b0010_0100 for 5 cycles -> freq_out=330, note_idx=2, tone_en=1; release -> tone_en=0, busy=0 one cycle later.
REQ-036 During sequence note 3, key_req=8'h80 -> freq_out=523, state LIVE; release -> IDLE, no sequence resume.
REQ-037 play_stop during SEQ_GAP -> IDLE next cycle; play_start+play_stop together in IDLE -> busy stays 0.
REQ-038 reset asserted during SEQ_NOTE note 5 -> next cycle freq_out=262, tone_en=0, note_idx=0, busy=0.

Source files
------------

// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - note table, FSM state type and helpers shared by tone_scheduler
//
// Holds the eight-entry note frequency table, the scheduler state enum,
// the NOTE_COUNT constant and the fixed-priority key arbiter.
// No ports; import with tone_pkg::*.
package tone_pkg;

  localparam int NOTE_COUNT = 8;
  localparam logic [31:0] RESET_FREQ = 32'd262;

  typedef enum logic [1:0] {
    IDLE,
    LIVE,
    SEQ_NOTE,
    SEQ_GAP
  } tone_state_e;

  // Frequency in Hz of note idx; every entry is non-zero.
  function automatic logic [31:0] note_freq(input logic [2:0] idx);
    case (idx)
      3'd0:    note_freq = 32'd262;
      3'd1:    note_freq = 32'd294;
      3'd2:    note_freq = 32'd330;
      3'd3:    note_freq = 32'd349;
      3'd4:    note_freq = 32'd392;
      3'd5:    note_freq = 32'd440;
      3'd6:    note_freq = 32'd494;
      default: note_freq = 32'd523;
    endcase
  endfunction

  // Fixed priority: the lowest set bit wins. Scanning from the top down
  // lets the last hit (the lowest index) overwrite any earlier one.
  function automatic logic [2:0] lowest_key(input logic [7:0] keys);
    lowest_key = 3'd0;
    for (int i = NOTE_COUNT - 1; i >= 0; i--) begin
      if (keys[i]) lowest_key = 3'(i);
    end
  endfunction

endpackage

// File: rtl/tone_scheduler_if.sv
// rtl/tone_scheduler_if.sv - request/response bundle between a controller and tone_scheduler
//
// master: drives key_req[7:0], play_start, play_stop; reads the tone outputs.
// slave : reads the requests; drives freq_out[31:0], tone_en, busy, note_idx[2:0].
interface tone_scheduler_if;

  logic [7:0]  key_req;
  logic        play_start;
  logic        play_stop;
  logic [31:0] freq_out;
  logic        tone_en;
  logic        busy;
  logic [2:0]  note_idx;

  modport master (
    output key_req, play_start, play_stop,
    input  freq_out, tone_en, busy, note_idx
  );

  modport slave (
    input  key_req, play_start, play_stop,
    output freq_out, tone_en, busy, note_idx
  );

endinterface

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond time base with synchronous clear
//
// Ports:
//   in_clk  - clock
//   reset   - synchronous, active-high
//   clear   - synchronous restart of the prescaler
//   ms_tick - high for one cycle every TICKS_PER_MS cycles after a clear
module ms_tick_gen #(
  parameter logic [31:0] TICKS_PER_MS = 32'd50_000
) (
  input  logic in_clk,
  input  logic reset,
  input  logic clear,
  output logic ms_tick
);

  logic [31:0] presc_q;

  // Tick on the last cycle of each ms so the consumer sees it in the same cycle
  // the ms completes.
  assign ms_tick = (presc_q == TICKS_PER_MS - 32'd1);

  always_ff @(posedge in_clk) begin
    if (reset || clear) begin
      presc_q <= '0;
    end else if (ms_tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 32'd1;
    end
  end

endmodule

// File: rtl/tone_scheduler.sv
// rtl/tone_scheduler.sv - live-key / scale-playback tone selector
//
// Ports:
//   in_clk - clock, all logic on the rising edge
//   reset  - synchronous, active-high
//   bus    - tone_scheduler_if.slave:
//              key_req[7:0] held notes, play_start / play_stop pulses in;
//              freq_out[31:0] Hz, tone_en, busy, note_idx[2:0] out (all registered)
module tone_scheduler
  import tone_pkg::*;
#(
  parameter logic [31:0] TICKS_PER_MS = 32'd50_000,
  parameter logic [15:0] NOTE_MS      = 16'd500,
  parameter logic [15:0] GAP_MS       = 16'd50
) (
  input  logic             in_clk,
  input  logic             reset,
  tone_scheduler_if.slave  bus
);

  localparam logic [31:0] NOTE_LAST_MS = {16'd0, NOTE_MS} - 32'd1;
  localparam logic [31:0] GAP_LAST_MS  = {16'd0, GAP_MS} - 32'd1;
  localparam logic [2:0]  LAST_NOTE    = 3'(NOTE_COUNT - 1);

  tone_state_e state_q, state_d;
  logic [31:0] freq_q, freq_d;
  logic        tone_q, tone_d;
  logic        busy_q;
  logic [2:0]  idx_q, idx_d;

  logic [31:0] ms_cnt_q;
  logic        ms_tick;
  logic        ms_clear;
  logic        key_any;
  logic [2:0]  key_win;
  logic        note_done;
  logic        gap_done;

  assign key_any   = |bus.key_req;
  assign key_win   = lowest_key(bus.key_req);
  assign note_done = ms_tick && (ms_cnt_q == NOTE_LAST_MS);
  assign gap_done  = ms_tick && (ms_cnt_q == GAP_LAST_MS);

  // Restart timing on every state change (including GAP->NOTE) and keep it
  // parked outside playback, so each note/gap starts from a fresh ms boundary.
  assign ms_clear = (state_d != state_q) || (state_d == IDLE) || (state_d == LIVE);

  ms_tick_gen #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_ms_tick (
    .in_clk (in_clk),
    .reset  (reset),
    .clear  (ms_clear),
    .ms_tick(ms_tick)
  );

  always_ff @(posedge in_clk) begin
    if (reset || ms_clear) begin
      ms_cnt_q <= '0;
    end else if (ms_tick) begin
      ms_cnt_q <= ms_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_q <= IDLE;
      freq_q  <= RESET_FREQ;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      tone_q  <= tone_d;
      busy_q  <= (state_d != IDLE);
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    tone_d  = tone_q;
    idx_d   = idx_q;

    if (key_any) begin
      // Held keys win from every state, including over play_stop.
      state_d = LIVE;
      idx_d   = key_win;
      freq_d  = note_freq(key_win);
      tone_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tone_d = 1'b0;
          if (bus.play_start && !bus.play_stop) begin
            state_d = SEQ_NOTE;
            idx_d   = 3'd0;
            freq_d  = note_freq(3'd0);
            tone_d  = 1'b1;
          end
        end
        LIVE: begin
          state_d = IDLE;
          tone_d  = 1'b0;
        end
        SEQ_NOTE: begin
          tone_d = 1'b1;
          if (bus.play_stop) begin
            state_d = IDLE;
            tone_d  = 1'b0;
          end else if (note_done) begin
            state_d = SEQ_GAP;
            tone_d  = 1'b0;
          end
        end
        SEQ_GAP: begin
          tone_d = 1'b0;
          if (bus.play_stop) begin
            state_d = IDLE;
          end else if (gap_done) begin
            if (idx_q == LAST_NOTE) begin
              state_d = IDLE;
            end else begin
              state_d = SEQ_NOTE;
              idx_d   = idx_q + 3'd1;
              freq_d  = note_freq(idx_q + 3'd1);
              tone_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          tone_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.freq_out = freq_q;
  assign bus.tone_en  = tone_q;
  assign bus.busy     = busy_q;
  assign bus.note_idx = idx_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// tb/tb_tone_scheduler.sv - scoreboard bench for tone_scheduler
module tb_tone_scheduler;

  localparam logic [31:0] TICKS    = 32'd2;
  localparam logic [15:0] NOTE_MS  = 16'd3;
  localparam logic [15:0] GAP_MS   = 16'd1;
  localparam int          NOTE_CYC = 6;
  localparam int          PERIOD   = 8;

  typedef struct packed {
    logic [31:0] freq;
    logic        tone;
    logic        busy;
    logic [2:0]  idx;
  } obs_t;

  logic in_clk = 1'b0;
  logic reset;

  tone_scheduler_if bus ();

  tone_scheduler #(
    .TICKS_PER_MS(TICKS),
    .NOTE_MS     (NOTE_MS),
    .GAP_MS      (GAP_MS)
  ) dut (
    .in_clk(in_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 in_clk = ~in_clk;

  obs_t  exp_q[$];
  string tag_q[$];
  string tag;
  int    vectors     = 0;
  int    miscompares = 0;

  int hz [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

  // Reference model: mode 0 = idle, 1 = live, 2 = scale playback.
  // During playback m_t counts cycles since the start edge.
  int m_mode = 0;
  int m_t    = 0;
  int m_idx  = 0;
  int m_freq = 262;
  bit m_tone = 0;

  task automatic model_step(input logic rst, input logic [7:0] key,
                            input logic start, input logic stop);
    obs_t e;
    if (rst) begin
      m_mode = 0; m_freq = 262; m_idx = 0; m_tone = 0;
    end else if (key != 8'h00) begin
      m_mode = 1;
      m_idx  = 0;
      while (!key[m_idx]) m_idx++;
      m_freq = hz[m_idx];
      m_tone = 1;
    end else if (m_mode == 1) begin
      m_mode = 0; m_tone = 0;
    end else if (m_mode == 0) begin
      if (start && !stop) begin
        m_mode = 2; m_t = 0;
      end
    end else begin
      if (stop) begin
        m_mode = 0; m_tone = 0;
      end else begin
        m_t++;
        if (m_t == 8 * PERIOD) begin
          m_mode = 0; m_tone = 0;
        end
      end
    end
    if (m_mode == 2) begin
      m_idx  = m_t / PERIOD;
      m_freq = hz[m_idx];
      m_tone = (m_t % PERIOD) < NOTE_CYC;
    end
    e.freq = 32'(m_freq);
    e.tone = m_tone;
    e.busy = (m_mode != 0);
    e.idx  = 3'(m_idx);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic drive(input logic rst, input logic [7:0] key,
                       input logic start, input logic stop);
    @(negedge in_clk);
    reset          = rst;
    bus.key_req    = key;
    bus.play_start = start;
    bus.play_stop  = stop;
    model_step(rst, key, start, stop);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: one expectation per clock edge, compared just after that edge.
  initial begin
    obs_t  got;
    obs_t  e;
    string t;
    forever begin
      @(posedge in_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        got.freq = bus.freq_out;
        got.tone = bus.tone_en;
        got.busy = bus.busy;
        got.idx  = bus.note_idx;
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL %s @%0t: got freq=%0d tone=%0b busy=%0b idx=%0d, expected freq=%0d tone=%0b busy=%0b idx=%0d",
                   t, $time, got.freq, got.tone, got.busy, got.idx,
                   e.freq, e.tone, e.busy, e.idx);
        end
      end
    end
  end

  initial begin
    logic [7:0] k;
    logic       s;
    logic       p;
    logic       r;
    reset          = 1'b1;
    bus.key_req    = 8'h00;
    bus.play_start = 1'b0;
    bus.play_stop  = 1'b0;

    tag = "reset";           repeat (3) drive(1'b1, 8'h00, 1'b0, 1'b0);
    tag = "idle10";          idle(10);
    tag = "scale";           drive(1'b0, 8'h00, 1'b1, 1'b0); idle(70);
    tag = "live_keys";       repeat (5) drive(1'b0, 8'b0010_0100, 1'b0, 1'b0); idle(3);
    tag = "preempt_note3";   drive(1'b0, 8'h00, 1'b1, 1'b0); idle(26);
                             repeat (4) drive(1'b0, 8'h80, 1'b0, 1'b0); idle(12);
    tag = "stop_in_gap";     drive(1'b0, 8'h00, 1'b1, 1'b0); idle(6);
                             drive(1'b0, 8'h00, 1'b0, 1'b1); idle(3);
    tag = "start_stop_idle"; drive(1'b0, 8'h00, 1'b1, 1'b1); idle(3);
    tag = "restart_ignored"; drive(1'b0, 8'h00, 1'b1, 1'b0); idle(10);
                             drive(1'b0, 8'h00, 1'b1, 1'b0); idle(60);
    tag = "stop_key_same";   drive(1'b0, 8'h00, 1'b1, 1'b0); idle(3);
                             drive(1'b0, 8'h12, 1'b0, 1'b1); idle(3);
    tag = "reset_note5";     drive(1'b0, 8'h00, 1'b1, 1'b0); idle(42);
                             drive(1'b1, 8'h00, 1'b0, 1'b0); idle(5);

    tag = "random";
    for (int i = 0; i < 1500; i++) begin
      k = ($urandom_range(0, 99) < 8) ? 8'($urandom) : 8'h00;
      s = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 199) == 0);
      drive(r, k, s, p);
    end

    repeat (2) @(posedge in_clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
